serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder that adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Each cycle evaluates a single full-adder cell: {c_next, s} = a_bit + b_bit + carry. The carry is held in a flip-flop between cycles.
- Intended as the area-minimal sequential front-end around the team's 1-bit adder cell, for datapaths where latency is cheap and gates are not.
- Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid (high only in DONE).
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  carry-out (bit WIDTH of a+b+cin).
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (rst_n=0, takes effect immediately, without waiting for a clock edge):
  - state=IDLE; operand shift registers, sum shift register, carry register and bit counter all cleared.
  - Outputs: sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
- State machine, three states:
  - IDLE -> ADD on in_valid & in_ready.
  - ADD -> DONE after WIDTH ADD cycles.
  - DONE -> IDLE on out_ready.
- IDLE:
  - in_ready=1.
  - On acceptance: latch a, b into shift registers, carry<=cin, counter<=0, clear sum register.
- ADD, each cycle:
  - s = a_sh[0]^b_sh[0]^carry; c_next = majority(a_sh[0], b_sh[0], carry).
  - a_sh, b_sh shift right by one; s shifts into sum register MSB (sum register shifts right); carry<=c_next; counter++.
  - On the cycle where counter==WIDTH-1: move to DONE. The result is then fully aligned in the sum register, and cout=carry.
- Latency: accepted on edge k -> out_valid first high after edge k+WIDTH (i.e. WIDTH cycles in ADD).
- DONE:
  - out_valid=1; sum and cout held stable until the handshake completes.
  - On out_valid & out_ready: move to IDLE. in_ready rises the following cycle, so there are no same-cycle back-to-back transactions. Throughput is one add per WIDTH+2 cycles with out_ready held high.
- sum/cout after DONE: retain the last result in IDLE until the next acceptance clears the sum register. out_valid is the only qualifier.
- in_valid and operand changes outside IDLE: ignored (in_ready=0); operands are never sampled mid-operation.
- out_ready outside DONE: no effect.
- Width rules:
  - Counter is clog2(WIDTH+1) bits, minimum 1.
  - Result {cout,sum} equals (a+b+cin) mod 2^(WIDTH+1) exactly.
- WIDTH=1: exactly one ADD cycle; must still work correctly.
- Reset mid-operation (ADD or DONE): aborts the operation; all outputs return to reset values at once; no partial result is presented. After rst_n rises the block is in IDLE and accepts a new operation normally.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, cin=0 accepted at edge k -> out_valid high after edge k+8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/cout stable, in_ready=0, new operands not taken. out_ready=1 -> IDLE, in_ready=1 next cycle, pending operands then accepted.
- Reset mid-op: assert rst_n=0 during the 3rd ADD cycle -> outputs immediately 0, busy=0, in_ready=1. Release reset, issue 0x12+0x34 -> sum=0x46, cout=0.
- Random: 1000 transactions, with in_valid and out_ready randomly toggled, on WIDTH=8 and WIDTH=1 instances. Each {cout,sum} must match a+b+cin; transaction order must be preserved; no result lost or duplicated.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder of a+b+cin, one full-adder cell per clock; WIDTH cycles in ADD.
// Valid/ready on both sides: operands taken only in IDLE, result held in DONE until out_ready.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_next, last;

  assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the result is aligned after exactly WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= (sum_sh >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
          carry  <= c_next;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: directed cases and random traffic on WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  localparam int NTX = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic       rst_n, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       rst1_n, in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8));

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1));

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int acc8 = 0, acc1 = 0;
  bit done1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition, pushed when the operands are accepted.
  always @(negedge clk) begin
    if (rst_n && in_valid8 && in_ready8) begin
      q8.push_back(9'(int'(a8) + int'(b8) + int'(cin8)));
      acc8++;
    end
    if (rst1_n && in_valid1 && in_ready1) begin
      q1.push_back(2'(int'(a1) + int'(b1) + int'(cin1)));
      acc1++;
    end
  end

  // Result monitors: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("w8_unexpected_result", {23'd0, cout8, sum8}, 32'hdead);
      else                chk("w8_result", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
    end
    if (rst1_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("w1_unexpected_result", {30'd0, cout1, sum1}, 32'hdead);
      else                chk("w1_result", {30'd0, cout1, sum1}, {30'd0, q1.pop_front()});
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int n = 0;
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    while (!in_ready8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("w8_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("w8_result_timeout", 32'(n), 32'd0);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // WIDTH=1 random traffic
  initial begin
    int cyc = 0;
    rst1_n = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2;
    chk("w1_reset_in_ready", 32'(in_ready1), 32'd1);
    chk("w1_reset_busy", 32'(busy1), 32'd0);
    @(negedge clk); rst1_n = 1'b1;
    while (acc1 < NTX && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      in_valid1  = 1'($urandom_range(0, 1));
      a1         = 1'($urandom);
      b1         = 1'($urandom);
      cin1       = 1'($urandom);
      out_ready1 = 1'($urandom_range(0, 1));
    end
    chk("w1_all_accepted", 32'(acc1), 32'(NTX));
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    cyc = 0;
    while (q1.size() != 0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("w1_drain", 32'(q1.size()), 32'd0);
    done1 = 1'b1;
  end

  // WIDTH=8 directed then random traffic
  initial begin
    int cyc;
    rst_n = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    #2;
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Latency: out_valid low after edges k..k+7, high after k+8.
    send8(8'h5A, 8'h3C, 1'b0);
    chk("lat_busy", 32'(busy8), 32'd1);
    chk("lat_in_ready", 32'(in_ready8), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("lat_out_valid_low", 32'(out_valid8), 32'd0);
      @(posedge clk); #1;
    end
    chk("lat_out_valid_high", 32'(out_valid8), 32'd1);
    chk("lat_sum", 32'(sum8), 32'h96);
    @(posedge clk); #1;
    chk("post_done_in_ready", 32'(in_ready8), 32'd1);
    chk("post_done_sum_held", 32'(sum8), 32'h96);

    send8(8'hFF, 8'h01, 1'b0); wait_done8();
    send8(8'hFF, 8'hFF, 1'b1); wait_done8();
    send8(8'h00, 8'h00, 1'b0); wait_done8();

    // Backpressure in DONE with new operands pending.
    out_ready8 = 1'b0;
    send8(8'h11, 8'h22, 1'b0);
    cyc = 0;
    while (!out_valid8 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    a8 = 8'h77; b8 = 8'h08; cin8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum", 32'(sum8), 32'h33);
      chk("bp_cout", 32'(cout8), 32'd0);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready8), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid8), 32'd0);
    @(posedge clk); #1;
    chk("bp_pending_taken", 32'(busy8), 32'd1);
    in_valid8 = 1'b0;
    wait_done8();

    // Reset during the third ADD cycle.
    send8(8'hAA, 8'h55, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    q8.delete();
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_cout", 32'(cout8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_in_ready", 32'(in_ready8), 32'd1);
    chk("midrst_out_valid", 32'(out_valid8), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    send8(8'h12, 8'h34, 1'b0);
    wait_done8();
    chk("after_rst_sum", 32'(sum8), 32'h46);

    // Random traffic
    acc8 = 0; cyc = 0;
    while (acc8 < NTX && cyc < 40000) begin
      @(posedge clk); #1; cyc++;
      in_valid8  = 1'($urandom_range(0, 1));
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      cin8       = 1'($urandom);
      out_ready8 = 1'($urandom_range(0, 1));
    end
    chk("w8_all_accepted", 32'(acc8), 32'(NTX));
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    cyc = 0;
    while (q8.size() != 0 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("w8_drain", 32'(q8.size()), 32'd0);

    cyc = 0;
    while (!done1 && cyc < 40000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("w1_finished", 32'(done1), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
